// File: rtl/match_grid_ctrl.sv
// match_grid_ctrl: tile-matching game controller driving a single-port tile RAM
// Ports: clk, clear (synchronous active-low reset); game_en/user_quit from the menu FSM;
//   btn_up/down/left/right/select debounced levels; mem_addr/mem_we/mem_wdata/mem_rdata
//   tile RAM port; moves/pairs score; game_won/game_lost sticky result; busy/state_dbg status.
module match_grid_ctrl #(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int TILE_W = 8,
    parameter int RD_LAT = 1,
    parameter int REVEAL_CYCLES = 100000000,
    parameter int WRAP = 0,
    parameter int MAX_MOVES = 0,
    parameter int SCORE_W = 8,
    localparam int N = ROWS * COLS,
    localparam int ADDR_W = $clog2(N),
    localparam int PAIR_W = $clog2(N / 2 + 1)
) (
    input  logic               clk,
    input  logic               clear,
    input  logic               game_en,
    input  logic               user_quit,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic               btn_left,
    input  logic               btn_right,
    input  logic               btn_select,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_we,
    output logic [TILE_W-1:0]  mem_wdata,
    input  logic [TILE_W-1:0]  mem_rdata,
    output logic [SCORE_W-1:0] moves,
    output logic [PAIR_W-1:0]  pairs,
    output logic               game_won,
    output logic               game_lost,
    output logic               busy,
    output logic [3:0]         state_dbg
);
    localparam int RC_W = REVEAL_CYCLES > 1 ? $clog2(REVEAL_CYCLES) : 1;
    typedef enum logic [3:0] {
        IDLE, CUR_INIT, SELECT, MOVE_OLD, MOVE_NEW, FLIP, REVEAL, COMPARE, HIDE_A, HIDE_B, CHECK, DONE
    } stateT;
    stateT state;
    logic [1:0] phase;
    logic [ADDR_W-1:0] cursor, newCursor, locA, locB, curRow, curCol, target;
    logic [TILE_W-3:0] idA, idB;
    logic [N-1:0] bitmap;
    logic [RC_W-1:0] revealCnt;
    logic [4:0] prevBtn, btnNow, pulse;
    logic holdFirst, enLow, abort, rmwState, rmwLast, moveOk, selOk;

    assign btnNow = {btn_up, btn_down, btn_left, btn_right, btn_select};
    assign pulse = btnNow & ~prevBtn;
    assign curRow = cursor / ADDR_W'(COLS);
    assign curCol = cursor % ADDR_W'(COLS);
    assign abort = state != DONE && (user_quit || !game_en);
    assign rmwState = state inside {CUR_INIT, MOVE_OLD, MOVE_NEW, FLIP};
    // the write beat of a read-modify-write lands exactly when the read data arrives
    assign rmwLast = rmwState && phase == 2'(RD_LAT);
    assign mem_we = !abort && (rmwLast || state == HIDE_A || state == HIDE_B);
    assign busy = state != IDLE && state != SELECT;
    assign state_dbg = state;
    assign selOk = pulse == 5'b00001 && !bitmap[cursor] && !(holdFirst && cursor == locA);

    // only the highest-priority pulse is considered; an illegal move drops the rest
    always_comb begin
        target = cursor;
        moveOk = 1'b0;
        if (pulse[4]) begin
            moveOk = curRow != '0 || WRAP != 0;
            target = curRow != '0 ? cursor - ADDR_W'(COLS) : cursor + ADDR_W'((ROWS - 1) * COLS);
        end else if (pulse[3]) begin
            moveOk = curRow != ADDR_W'(ROWS - 1) || WRAP != 0;
            target = curRow != ADDR_W'(ROWS - 1) ? cursor + ADDR_W'(COLS) : cursor - ADDR_W'((ROWS - 1) * COLS);
        end else if (pulse[2]) begin
            moveOk = curCol != '0 || WRAP != 0;
            target = curCol != '0 ? cursor - ADDR_W'(1) : cursor + ADDR_W'(COLS - 1);
        end else if (pulse[1]) begin
            moveOk = curCol != ADDR_W'(COLS - 1) || WRAP != 0;
            target = curCol != ADDR_W'(COLS - 1) ? cursor + ADDR_W'(1) : cursor - ADDR_W'(COLS - 1);
        end
    end

    // hide writes rebuild the tile from the latched ID, keeping the cursor bit where it sits now
    always_comb begin
        mem_wdata = (state == CUR_INIT || state == MOVE_NEW) ? mem_rdata | TILE_W'(1)
                  : state == MOVE_OLD ? mem_rdata & ~TILE_W'(1)
                  : state == FLIP ? mem_rdata | TILE_W'(2)
                  : state == HIDE_A ? {idA, 1'b0, locA == cursor}
                  : state == HIDE_B ? {idB, 1'b0, locB == cursor} : '0;
    end

    always_ff @(posedge clk) begin
        prevBtn <= btnNow;
        if (!clear) begin
            state <= IDLE;
            phase <= '0;
            mem_addr <= '0;
            cursor <= '0;
            newCursor <= '0;
            locA <= '0;
            locB <= '0;
            idA <= '0;
            idB <= '0;
            bitmap <= '0;
            revealCnt <= '0;
            holdFirst <= 1'b0;
            enLow <= 1'b0;
            moves <= '0;
            pairs <= '0;
            game_won <= 1'b0;
            game_lost <= 1'b0;
        end else if (abort) begin
            state <= IDLE;
            phase <= '0;
            holdFirst <= 1'b0;
        end else begin
            phase <= rmwState && !rmwLast ? phase + 2'd1 : 2'd0;
            case (state)
                IDLE: begin
                    state <= CUR_INIT;
                    mem_addr <= '0;
                    cursor <= '0;
                    bitmap <= '0;
                    holdFirst <= 1'b0;
                    moves <= '0;
                    pairs <= '0;
                    game_won <= 1'b0;
                    game_lost <= 1'b0;
                end
                CUR_INIT: if (rmwLast) state <= SELECT;
                SELECT: begin
                    if (moveOk) begin
                        newCursor <= target;
                        mem_addr <= cursor;
                        state <= MOVE_OLD;
                    end else if (selOk) begin
                        mem_addr <= cursor;
                        state <= FLIP;
                    end
                end
                MOVE_OLD: if (rmwLast) begin
                    mem_addr <= newCursor;
                    state <= MOVE_NEW;
                end
                MOVE_NEW: if (rmwLast) begin
                    cursor <= newCursor;
                    state <= SELECT;
                end
                FLIP: if (rmwLast) begin
                    holdFirst <= !holdFirst;
                    if (holdFirst) begin
                        idB <= mem_rdata[TILE_W-1:2];
                        locB <= cursor;
                        revealCnt <= RC_W'(REVEAL_CYCLES - 1);
                        state <= REVEAL;
                    end else begin
                        idA <= mem_rdata[TILE_W-1:2];
                        locA <= cursor;
                        state <= SELECT;
                    end
                end
                REVEAL: begin
                    if (revealCnt == '0) state <= COMPARE;
                    else revealCnt <= revealCnt - RC_W'(1);
                end
                COMPARE: begin
                    moves <= moves + SCORE_W'(moves != '1);
                    if (idA == idB) begin
                        bitmap[locA] <= 1'b1;
                        bitmap[locB] <= 1'b1;
                        pairs <= pairs + PAIR_W'(1);
                        state <= CHECK;
                    end else begin
                        mem_addr <= locA;
                        state <= HIDE_A;
                    end
                end
                HIDE_A: begin
                    mem_addr <= locB;
                    state <= HIDE_B;
                end
                HIDE_B: state <= CHECK;
                CHECK: begin
                    enLow <= 1'b0;
                    if (pairs == PAIR_W'(N / 2)) begin
                        game_won <= 1'b1;
                        state <= DONE;
                    end else if (MAX_MOVES != 0 && moves == SCORE_W'(MAX_MOVES)) begin
                        game_lost <= 1'b1;
                        state <= DONE;
                    end else state <= SELECT;
                end
                DONE: begin
                    // restart needs a quit or a full fall-then-rise of game_en
                    if (user_quit || (enLow && game_en)) begin
                        state <= IDLE;
                        game_won <= 1'b0;
                        game_lost <= 1'b0;
                    end else if (!game_en) enLow <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_match_grid_ctrl.sv
// tb_match_grid_ctrl: directed bench for three controller variants sharing one button set
module tb_match_grid_ctrl;
    localparam logic [95:0] IDS = {6'd7, 6'd7, 6'd4, 6'd4, 6'd3, 6'd3, 6'd2, 6'd2,
                                   6'd1, 6'd1, 6'd5, 6'd6, 6'd6, 6'd5, 6'd5, 6'd5};
    logic clk = 1'b0;
    logic clear, gameEn, enC, userQuit, ramInit;
    logic btnUp, btnDown, btnLeft, btnRight, btnSel;
    logic [2:0] en, we, won, lost, busy;
    logic [11:0] addr, pairs, sdbg;
    logic [23:0] wdata, rdata, moves;
    logic [95:0] wcV, weCycV, mvCycV;
    logic [143:0] lastW;
    int cyc = 0;
    int errors = 0;
    int checks = 0;
    int cur = 0;

    always #5 clk = ~clk;
    always @(negedge clk) cyc <= cyc + 1;

    // instance 0: RD_LAT=1 clamp; 1: RD_LAT=2 clamp, MAX_MOVES=2; 2: RD_LAT=1 wrap
    for (genvar g = 0; g < 3; g++) begin : inst
        localparam int RDL = g == 1 ? 2 : 1;
        logic [7:0] mem [16];
        logic [7:0] rd1, rd2;
        logic [7:0] pm = '0;
        logic [31:0] wcL = '0, weC = '0, mvC = '0;
        logic [47:0] lw = '0;
        assign en[g] = g == 2 ? enC : gameEn;
        assign rdata[g*8 +: 8] = RDL == 2 ? rd2 : rd1;
        assign wcV[g*32 +: 32] = wcL;
        assign weCycV[g*32 +: 32] = weC;
        assign mvCycV[g*32 +: 32] = mvC;
        assign lastW[g*48 +: 48] = lw;
        match_grid_ctrl #(.RD_LAT(RDL), .REVEAL_CYCLES(4), .WRAP(g == 2 ? 1 : 0),
                          .MAX_MOVES(g == 1 ? 2 : 0)) dut (
            .clk(clk), .clear(clear), .game_en(en[g]), .user_quit(userQuit),
            .btn_up(btnUp), .btn_down(btnDown), .btn_left(btnLeft), .btn_right(btnRight),
            .btn_select(btnSel), .mem_addr(addr[g*4 +: 4]), .mem_we(we[g]),
            .mem_wdata(wdata[g*8 +: 8]), .mem_rdata(rdata[g*8 +: 8]), .moves(moves[g*8 +: 8]),
            .pairs(pairs[g*4 +: 4]), .game_won(won[g]), .game_lost(lost[g]), .busy(busy[g]),
            .state_dbg(sdbg[g*4 +: 4])
        );
        always @(posedge clk) begin
            rd1 <= mem[addr[g*4 +: 4]];
            rd2 <= rd1;
            if (ramInit) begin
                for (int i = 0; i < 16; i++) mem[i] <= {IDS[i*6 +: 6], 2'b00};
            end else if (we[g]) mem[addr[g*4 +: 4]] <= wdata[g*8 +: 8];
            if (we[g]) begin
                lw <= {lw[35:0], addr[g*4 +: 4], wdata[g*8 +: 8]};
                wcL <= wcL + 1;
            end
        end
        always @(negedge clk) begin
            if (we[g]) weC <= cyc;
            if (moves[g*8 +: 8] != pm) mvC <= cyc;
            pm <= moves[g*8 +: 8];
        end
    end

    function automatic int wcOf(input int g);
        return int'(wcV[g*32 +: 32]);
    endfunction

    function automatic logic [11:0] lastOf(input int g, input int k);
        return lastW[g*48 + k*12 +: 12];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic settle();
        int n = 0;
        while (n < 400 && !(&(~busy | won | lost))) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            checks++;
            errors++;
            $error("FAIL settle timeout: observed busy=%b expected idle", busy);
        end
    endtask

    task automatic press(input int b);
        logic [4:0] v;
        v = 5'b10000 >> b;
        @(negedge clk);
        {btnUp, btnDown, btnLeft, btnRight, btnSel} = v;
        @(negedge clk);
        {btnUp, btnDown, btnLeft, btnRight, btnSel} = '0;
        @(negedge clk);
        settle();
    endtask

    task automatic nav(input int t);
        while (cur != t) begin
            if (cur / 4 < t / 4) begin press(1); cur += 4; end
            else if (cur / 4 > t / 4) begin press(0); cur -= 4; end
            else if (cur % 4 < t % 4) begin press(3); cur++; end
            else begin press(2); cur--; end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1);
    end

    initial begin
        int b0, b1, b2, n;
        int pa [7];
        int pb [7];
        pa = '{3, 2, 6, 8, 10, 12, 14};
        pb = '{4, 5, 7, 9, 11, 13, 15};
        clear = 1'b0; gameEn = 1'b0; enC = 1'b0; userQuit = 1'b0; ramInit = 1'b1;
        {btnUp, btnDown, btnLeft, btnSel} = '0;
        btnRight = 1'b1;
        repeat (3) @(negedge clk);
        ramInit = 1'b0;
        for (int g = 0; g < 3; g++)
            chk($sformatf("reset outputs %0d", g), {sdbg[g*4 +: 4], addr[g*4 +: 4], moves[g*8 +: 8],
                pairs[g*4 +: 4], busy[g], we[g], won[g], lost[g], wdata[g*8 +: 4]}, 32'h0);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        gameEn = 1'b1; enC = 1'b1;
        b0 = wcOf(0); b1 = wcOf(1); b2 = wcOf(2);
        repeat (2) @(negedge clk);
        settle();
        repeat (3) @(negedge clk);
        chk("init count A", wcOf(0) - b0, 1);
        chk("init count B", wcOf(1) - b1, 1);
        chk("init count C", wcOf(2) - b2, 1);
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("init write %0d", g), lastOf(g, 0), {4'd0, 8'h15});
            chk($sformatf("init busy %0d", g), busy[g], 0);
        end
        btnRight = 1'b0;

        b0 = wcOf(0); b1 = wcOf(1); b2 = wcOf(2);
        press(0);
        chk("up clamp A", wcOf(0) - b0, 0);
        chk("up clamp B", wcOf(1) - b1, 0);
        chk("up wrap count C", wcOf(2) - b2, 2);
        chk("up wrap old C", lastOf(2, 1), {4'd0, 8'h14});
        chk("up wrap new C", lastOf(2, 0), {4'd12, 8'h11});
        chk("tile0 cursor A", inst[0].mem[0], 8'h15);
        enC = 1'b0;
        repeat (2) @(negedge clk);
        chk("C idle state", sdbg[11:8], 0);

        press(4);
        chk("flip0 A", lastOf(0, 0), {4'd0, 8'h17});
        chk("flip0 B", lastOf(1, 0), {4'd0, 8'h17});
        press(3);
        cur = 1;
        chk("move old A", lastOf(0, 1), {4'd0, 8'h16});
        chk("move new A", lastOf(0, 0), {4'd1, 8'h15});
        b0 = wcOf(0); b1 = wcOf(1);
        press(4);
        chk("match writes A", wcOf(0) - b0, 1);
        chk("match writes B", wcOf(1) - b1, 1);
        chk("match moves A", moves[7:0], 1);
        chk("match pairs A", pairs[3:0], 1);
        chk("match moves B", moves[15:8], 1);
        chk("match pairs B", pairs[7:4], 1);
        chk("reveal gap A", mvCycV[31:0] - weCycV[31:0], 6);
        chk("reveal gap B", mvCycV[63:32] - weCycV[63:32], 6);

        press(2);
        cur = 0;
        b0 = wcOf(0);
        press(4);
        chk("matched select ignored A", wcOf(0) - b0, 0);

        nav(2);
        press(4);
        chk("flip2 A", lastOf(0, 0), {4'd2, 8'h17});
        press(3);
        cur = 3;
        b0 = wcOf(0); b1 = wcOf(1);
        press(4);
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("mismatch count %0d", g), wcOf(g) - (g == 0 ? b0 : b1), 3);
            chk($sformatf("flip3 %0d", g), lastOf(g, 2), {4'd3, 8'h1B});
            chk($sformatf("hideA %0d", g), lastOf(g, 1), {4'd2, 8'h14});
            chk($sformatf("hideB %0d", g), lastOf(g, 0), {4'd3, 8'h19});
            chk($sformatf("mismatch moves %0d", g), moves[g*8 +: 8], 2);
            chk($sformatf("mismatch pairs %0d", g), pairs[g*4 +: 4], 1);
        end
        chk("A flags after mismatch", {won[0], lost[0], busy[0]}, 3'b000);
        chk("B lost at move limit", {won[1], lost[1], busy[1]}, 3'b011);

        for (int p = 0; p < 7; p++) begin
            nav(pa[p]);
            press(4);
            nav(pb[p]);
            press(4);
        end
        chk("A won flags", {won[0], lost[0], busy[0]}, 3'b101);
        chk("A pairs", pairs[3:0], 8);
        chk("A moves", moves[7:0], 9);
        chk("A tile15", inst[0].mem[15], 8'h1F);
        chk("B unchanged in DONE", {lost[1], moves[15:8]}, {1'b1, 8'd2});
        b0 = wcOf(0);
        press(4);
        chk("DONE ignores select", {wcOf(0) - b0, 31'd0, won[0]}, 32'h1);

        gameEn = 1'b0;
        repeat (3) @(negedge clk);
        chk("won held while en low", won[0], 1);
        ramInit = 1'b1;
        @(negedge clk);
        ramInit = 1'b0;
        gameEn = 1'b1;
        repeat (3) @(negedge clk);
        settle();
        for (int g = 0; g < 2; g++)
            chk($sformatf("restart clears %0d", g), {won[g], lost[g], busy[g], moves[g*8 +: 8],
                pairs[g*4 +: 4]}, 32'h0);
        cur = 0;
        press(4);
        press(3);
        cur = 1;
        b0 = wcOf(0); b1 = wcOf(1);
        @(negedge clk);
        btnSel = 1'b1;
        @(negedge clk);
        btnSel = 1'b0;
        n = 0;
        while (wcOf(0) == b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("flip seen before quit", n < 20, 1);
        userQuit = 1'b1;
        #1;
        chk("B write abandoned", we[1], 0);
        chk("A no write in reveal", we[0], 0);
        @(negedge clk);
        chk("quit to IDLE A", {sdbg[3:0], 3'd0, busy[0]}, 8'h0);
        chk("quit to IDLE B", {sdbg[7:4], 3'd0, busy[1]}, 8'h0);
        chk("quit writes A", wcOf(0) - b0, 1);
        chk("quit writes B", wcOf(1) - b1, 0);
        chk("quit moves A", moves[7:0], 0);
        userQuit = 1'b0;
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
